// File: rtl/fixed_expand.sv
// Input formatter: signed integer complex samples to saturated Q format,
// with valid/ready flow control, frame index/sof/eof and saturation flags.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/o_ready       input handshake, i_real/i_imag integer samples
//   o_valid/i_ready       output handshake, o_real/o_imag Q-format samples
//   o_index, o_sof, o_eof frame position of the presented sample
//   o_sat, o_frame_sat    per-sample clip flag, per-frame clip flag at eof
module fixed_expand #(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int FRACTION_BIT = 14,
  parameter int FFT_POINT    = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [IN_WIDTH-1:0]          i_real,
  input  logic [IN_WIDTH-1:0]          i_imag,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [OUT_WIDTH-1:0]         o_real,
  output logic [OUT_WIDTH-1:0]         o_imag,
  output logic [$clog2(FFT_POINT)-1:0] o_index,
  output logic                         o_sof,
  output logic                         o_eof,
  output logic                         o_sat,
  output logic                         o_frame_sat
);

  localparam int IDX_W = $clog2(FFT_POINT);
  // Wide enough for the shifted input and both clip limits.
  localparam int FW = IN_WIDTH + FRACTION_BIT + OUT_WIDTH;

  localparam logic signed [FW-1:0] MAX_V =
    {{(FW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_V = ~MAX_V;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FFT_POINT - 1);

  // Returns {sat, value}.
  function automatic logic [OUT_WIDTH:0] expand(
    input logic [IN_WIDTH-1:0] x
  );
    logic signed [FW-1:0] full;
    full = $signed({{(FW-IN_WIDTH){x[IN_WIDTH-1]}}, x}) <<< FRACTION_BIT;
    if (full > MAX_V)
      expand = {1'b1, MAX_V[OUT_WIDTH-1:0]};
    else if (full < MIN_V)
      expand = {1'b1, MIN_V[OUT_WIDTH-1:0]};
    else
      expand = {1'b0, full[OUT_WIDTH-1:0]};
  endfunction

  logic [OUT_WIDTH:0] re_x;
  logic [OUT_WIDTH:0] im_x;
  logic               sat;
  logic               in_xfer;
  logic               out_xfer;
  logic [IDX_W-1:0]   count;
  logic               last;
  logic               acc;

  assign re_x     = expand(i_real);
  assign im_x     = expand(i_imag);
  assign sat      = re_x[OUT_WIDTH] | im_x[OUT_WIDTH];
  assign o_ready  = !o_valid || i_ready;
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;
  assign last     = (count == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_real      <= '0;
      o_imag      <= '0;
      o_index     <= '0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_sat       <= 1'b0;
      o_frame_sat <= 1'b0;
      count       <= '0;
      acc         <= 1'b0;
    end else if (in_xfer) begin
      o_valid <= 1'b1;
      o_real  <= re_x[OUT_WIDTH-1:0];
      o_imag  <= im_x[OUT_WIDTH-1:0];
      o_sat   <= sat;
      o_index <= count;
      o_sof   <= (count == '0);
      o_eof   <= last;
      count   <= count + IDX_W'(1);
      // The eof sample closes the frame; the next sample starts clean.
      if (last) begin
        o_frame_sat <= acc | sat;
        acc         <= 1'b0;
      end else begin
        o_frame_sat <= 1'b0;
        acc         <= acc | sat;
      end
    end else if (out_xfer) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_expand.sv
// Bench for fixed_expand: reference model plus directed frame,
// saturation, backpressure and reset scenarios.
module tb_fixed_expand;

  localparam int IW    = 16;
  localparam int OW    = 16;
  localparam int FB    = 14;
  localparam int NPT   = 64;
  localparam int IDX_W = 6;
  localparam int LOGN  = 1024;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [IW-1:0]    i_real = '0;
  logic [IW-1:0]    i_imag = '0;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [OW-1:0]    o_real;
  logic [OW-1:0]    o_imag;
  logic [IDX_W-1:0] o_index;
  logic             o_sof;
  logic             o_eof;
  logic             o_sat;
  logic             o_frame_sat;

  fixed_expand #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW),
    .FRACTION_BIT(FB), .FFT_POINT(NPT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_real(i_real), .i_imag(i_imag),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_real(o_real), .o_imag(o_imag),
    .o_index(o_index), .o_sof(o_sof), .o_eof(o_eof),
    .o_sat(o_sat), .o_frame_sat(o_frame_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0]    re;
    logic [OW-1:0]    im;
    logic [IDX_W-1:0] idx;
    logic             sof;
    logic             eof;
    logic             sat;
    logic             fsat;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit bp = 1'b0;

  exp_t q[$];
  int   m_cnt = 0;
  bit   m_acc = 1'b0;

  int            out_n = 0;
  logic [OW-1:0] re_log [LOGN];
  logic [OW-1:0] im_log [LOGN];
  int            idx_log[LOGN];
  bit            sof_log[LOGN];
  bit            eof_log[LOGN];
  bit            sat_log[LOGN];
  bit            fs_log [LOGN];
  int            cyc_log[LOGN];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic clip of x * 2^FB into OW signed bits.
  task automatic clip(input int x, output logic [OW-1:0] v, output bit s);
    longint full;
    longint hi;
    longint lo;
    full = longint'(x) * (longint'(1) << FB);
    hi   = (longint'(1) << (OW - 1)) - 1;
    lo   = -(longint'(1) << (OW - 1));
    s = 1'b0;
    if (full > hi) begin
      full = hi;
      s = 1'b1;
    end else if (full < lo) begin
      full = lo;
      s = 1'b1;
    end
    v = full[OW-1:0];
  endtask

  task automatic model(input int re, input int im, output exp_t e);
    bit sr;
    bit si;
    clip(re, e.re, sr);
    clip(im, e.im, si);
    e.sat = sr | si;
    e.idx = m_cnt[IDX_W-1:0];
    e.sof = (m_cnt == 0);
    e.eof = (m_cnt == NPT - 1);
    e.fsat = 1'b0;
    if (e.eof) begin
      e.fsat = m_acc | e.sat;
      m_acc = 1'b0;
    end else begin
      m_acc = m_acc | e.sat;
    end
    m_cnt = (m_cnt + 1) % NPT;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (i_rst) begin
        q.delete();
        m_cnt = 0;
        m_acc = 1'b0;
      end else begin
        chk("ready", o_ready, !o_valid || i_ready);
        chk("valid", o_valid, q.size() != 0);
        if (o_valid && q.size() != 0) begin
          e = q[0];
          chk("real", o_real, e.re);
          chk("imag", o_imag, e.im);
          chk("index", o_index, e.idx);
          chk("sof", o_sof, e.sof);
          chk("eof", o_eof, e.eof);
          chk("sat", o_sat, e.sat);
          chk("frame_sat", o_frame_sat, e.fsat);
        end
        if (o_valid && i_ready) begin
          if (out_n < LOGN) begin
            re_log[out_n]  = o_real;
            im_log[out_n]  = o_imag;
            idx_log[out_n] = int'(o_index);
            sof_log[out_n] = o_sof;
            eof_log[out_n] = o_eof;
            sat_log[out_n] = o_sat;
            fs_log[out_n]  = o_frame_sat;
            cyc_log[out_n] = cyc;
          end
          if (q.size() != 0) void'(q.pop_front());
          out_n++;
        end
        if (i_valid && o_ready) begin
          model(int'($signed(i_real)), int'($signed(i_imag)), e);
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input int re, input int im);
    bit acc;
    int n;
    i_real  = IW'(re);
    i_imag  = IW'(im);
    i_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (bp) i_ready = 1'($urandom_range(0, 1));
      if (acc) break;
      n++;
      if (n > 1000) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt_sof;
    int cnt_eof;
    int cnt_fs;
    int cnt_sat;
    int bad_idx;
    int v;

    // Reset and idle.
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_real", o_real, 0);
    chk("rst_imag", o_imag, 0);
    chk("rst_misc",
        {o_index, o_sof, o_eof, o_sat, o_frame_sat}, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Format.
    base = out_n;
    send(1, -1);
    send(0, -2);
    send(2, -3);
    idle(3);
    chk("fmt_count", out_n - base, 3);
    chk("fmt0", {re_log[base], im_log[base], sat_log[base]},
        {16'h4000, 16'hC000, 1'b0});
    chk("fmt1", {re_log[base+1], im_log[base+1], sat_log[base+1]},
        {16'h0000, 16'h8000, 1'b0});
    chk("fmt2", {re_log[base+2], im_log[base+2], sat_log[base+2]},
        {16'h7FFF, 16'h8000, 1'b1});

    // Framing.
    pulse_rst();
    base = out_n;
    for (int i = 0; i < 130; i++) begin
      case (i % 4)
        1:       v = 1;
        3:       v = -1;
        default: v = 0;
      endcase
      send(v, -v);
    end
    idle(3);
    chk("frm_count", out_n - base, 130);
    cnt_sof = 0;
    cnt_eof = 0;
    cnt_fs = 0;
    bad_idx = 0;
    for (int i = 0; i < 130; i++) begin
      cnt_sof += int'(sof_log[base+i]);
      cnt_eof += int'(eof_log[base+i]);
      cnt_fs  += int'(fs_log[base+i]);
      if (idx_log[base+i] != i % 64) bad_idx++;
    end
    chk("frm_sof", {cnt_sof[7:0], sof_log[base], sof_log[base+64],
                    sof_log[base+128]}, {8'd3, 3'b111});
    chk("frm_eof", {cnt_eof[7:0], eof_log[base+63], eof_log[base+127]},
        {8'd2, 2'b11});
    chk("frm_fsat", cnt_fs, 0);
    chk("frm_index", bad_idx, 0);
    chk("frm_rate", cyc_log[base+129] - cyc_log[base], 129);
    chk("frm_val1", {re_log[base+1], im_log[base+1]},
        {16'h4000, 16'hC000});

    // Frame saturation.
    pulse_rst();
    base = out_n;
    for (int i = 0; i < 128; i++) send((i == 10) ? 5 : 0, 0);
    idle(3);
    cnt_sat = 0;
    for (int i = 0; i < 128; i++) cnt_sat += int'(sat_log[base+i]);
    chk("fs_sat", {cnt_sat[7:0], sat_log[base+10]}, {8'd1, 1'b1});
    chk("fs_eof0", fs_log[base+63], 1);
    chk("fs_eof1", fs_log[base+127], 0);
    chk("fs_re10", re_log[base+10], 16'h7FFF);

    // Backpressure.
    pulse_rst();
    base = out_n;
    bp = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0)
        send(int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
      else
        send(int'($signed(16'($urandom))), int'($signed(16'($urandom))));
    end
    bp = 1'b0;
    idle(4);
    chk("bp_count", out_n - base, 100);

    // Reset mid-frame.
    pulse_rst();
    for (int i = 0; i < 20; i++) send((i == 5) ? 7 : 0, 0);
    pulse_rst();
    @(negedge clk);
    chk("mid_valid", o_valid, 0);
    @(posedge clk);
    #1;
    base = out_n;
    for (int i = 0; i < 64; i++) send(0, 0);
    idle(3);
    chk("mid_first", {idx_log[base][7:0], sof_log[base]}, {8'd0, 1'b1});
    chk("mid_fsat", {eof_log[base+63], fs_log[base+63]}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
